// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: queues ID branch predictions, resolves them in MM
// and issues a registered mispredict pulse with the corrected fetch PC.
module branch_resolve_unit #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             id_b,
  input  logic             id_predict_taken,
  input  logic [31:0]      id_PC,
  input  logic [31:0]      id_target,
  input  logic             mm_b,
  input  logic             mm_b_taken,
  input  logic             flush,
  output logic             mispredict,
  output logic [31:0]      redirect_pc,
  output logic             q_full,
  output logic             q_empty,
  output logic             err_overflow,
  output logic             err_underflow,
  output logic [CNT_W-1:0] cnt_branch,
  output logic [CNT_W-1:0] cnt_mispredict
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE = 1;
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [CNT_W-1:0] PERF_ONE = 1;

  typedef struct packed {
    logic        pred;
    logic [31:0] pc;
    logic [31:0] target;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_nxt;
  logic [AW-1:0] wr_nxt;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;
  logic          full;
  logic          empty;
  logic          do_pop;
  logic          do_push;
  logic          miss;
  logic          clear;
  logic          push_ovf;
  logic          pop_unf;
  logic [31:0]   actual_pc;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign q_full  = full;
  assign q_empty = empty;

  // A miss or flush kills every younger entry, including a same-cycle push.
  always_comb begin
    head      = mem[rd_ptr];
    do_pop    = mm_b && !empty;
    pop_unf   = mm_b && empty;
    actual_pc = mm_b_taken ? head.target : head.pc + 32'd8;
    miss      = do_pop && (head.pred != mm_b_taken);
    clear     = miss || flush;
    do_push   = id_b && !clear && (!full || do_pop);
    push_ovf  = id_b && !clear && full && !do_pop;
  end

  always_comb begin
    rd_nxt    = rd_ptr;
    wr_nxt    = wr_ptr;
    count_nxt = count;
    if (clear) begin
      rd_nxt    = '0;
      wr_nxt    = '0;
      count_nxt = '0;
    end else begin
      if (do_pop)  rd_nxt = rd_ptr + PTR_ONE;
      if (do_push) wr_nxt = wr_ptr + PTR_ONE;
      unique case ({do_push, do_pop})
        2'b10:   count_nxt = count + CNT_ONE;
        2'b01:   count_nxt = count - CNT_ONE;
        default: count_nxt = count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      mispredict     <= 1'b0;
      redirect_pc    <= '0;
      err_overflow   <= 1'b0;
      err_underflow  <= 1'b0;
      cnt_branch     <= '0;
      cnt_mispredict <= '0;
    end else begin
      rd_ptr      <= rd_nxt;
      wr_ptr      <= wr_nxt;
      count       <= count_nxt;
      mispredict  <= miss;
      redirect_pc <= miss ? actual_pc : '0;
      if (push_ovf) err_overflow  <= 1'b1;
      if (pop_unf)  err_underflow <= 1'b1;
      if (do_pop)   cnt_branch     <= cnt_branch + PERF_ONE;
      if (miss)     cnt_mispredict <= cnt_mispredict + PERF_ONE;
    end
  end

  // Payload storage is only read behind a valid count, so it needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= '{pred: id_predict_taken, pc: id_PC, target: id_target};
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed vector table plus randomized traffic
// checked against a queue-based reference model.
module tb_branch_resolve_unit;

  localparam int DEPTH = 4;
  localparam int CNT_W = 32;

  logic        clk;
  logic        resetn;
  logic        id_b;
  logic        id_predict_taken;
  logic [31:0] id_PC;
  logic [31:0] id_target;
  logic        mm_b;
  logic        mm_b_taken;
  logic        flush;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic        q_full;
  logic        q_empty;
  logic        err_overflow;
  logic        err_underflow;
  logic [CNT_W-1:0] cnt_branch;
  logic [CNT_W-1:0] cnt_mispredict;

  branch_resolve_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .resetn(resetn),
    .id_b(id_b),
    .id_predict_taken(id_predict_taken),
    .id_PC(id_PC),
    .id_target(id_target),
    .mm_b(mm_b),
    .mm_b_taken(mm_b_taken),
    .flush(flush),
    .mispredict(mispredict),
    .redirect_pc(redirect_pc),
    .q_full(q_full),
    .q_empty(q_empty),
    .err_overflow(err_overflow),
    .err_underflow(err_underflow),
    .cnt_branch(cnt_branch),
    .cnt_mispredict(cnt_mispredict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          pred;
    logic [31:0] pc;
    logic [31:0] tgt;
  } ent_t;

  typedef struct {
    bit b, p;
    logic [31:0] pc, tgt;
    bit m, t, f;
    bit x_mis;
    logic [31:0] x_red;
    bit x_full, x_empty;
    int unsigned x_cb, x_cm;
    bit x_of, x_uf;
  } vec_t;

  int total;
  int bad;

  ent_t        mq[$];
  int unsigned m_cb;
  int unsigned m_cm;
  bit          m_of;
  bit          m_uf;
  bit          m_mis;
  logic [31:0] m_red;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t v(bit b, bit p, logic [31:0] pc, logic [31:0] tgt,
                             bit m, bit t, bit f, bit mis, logic [31:0] red,
                             bit full, bit empty, int unsigned cb, int unsigned cm,
                             bit of, bit uf);
    vec_t r;
    r.b = b; r.p = p; r.pc = pc; r.tgt = tgt;
    r.m = m; r.t = t; r.f = f;
    r.x_mis = mis; r.x_red = red;
    r.x_full = full; r.x_empty = empty;
    r.x_cb = cb; r.x_cm = cm;
    r.x_of = of; r.x_uf = uf;
    return r;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_cb = 0; m_cm = 0;
    m_of = 0; m_uf = 0;
    m_mis = 0; m_red = '0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, " mispredict"}, mispredict, m_mis);
    if (m_mis) chk({tag, " redirect_pc"}, redirect_pc, m_red);
    chk({tag, " q_full"}, q_full, mq.size() == DEPTH);
    chk({tag, " q_empty"}, q_empty, mq.size() == 0);
    chk({tag, " err_overflow"}, err_overflow, m_of);
    chk({tag, " err_underflow"}, err_underflow, m_uf);
    chk({tag, " cnt_branch"}, cnt_branch, m_cb);
    chk({tag, " cnt_mispredict"}, cnt_mispredict, m_cm);
  endtask

  // Called at a falling edge; drives inputs, advances the model, then
  // checks at the next falling edge.
  task automatic step(input bit b, input bit p, input logic [31:0] pc,
                      input logic [31:0] tgt, input bit m, input bit t,
                      input bit f, input string tag);
    bit   miss;
    ent_t e;
    id_b = b; id_predict_taken = p; id_PC = pc; id_target = tgt;
    mm_b = m; mm_b_taken = t; flush = f;
    miss = 0;
    m_mis = 0;
    if (m) begin
      if (mq.size() == 0) m_uf = 1;
      else begin
        e = mq.pop_front();
        m_cb++;
        if (e.pred != t) begin
          miss = 1;
          m_cm++;
          m_mis = 1;
          m_red = t ? e.tgt : e.pc + 32'd8;
        end
      end
    end
    if (miss || f) mq.delete();
    else if (b) begin
      if (mq.size() < DEPTH) mq.push_back('{pred: p, pc: pc, tgt: tgt});
      else m_of = 1;
    end
    @(negedge clk);
    check_model(tag);
  endtask

  initial begin
    total = 0;
    bad = 0;
    id_b = 0; id_predict_taken = 0; id_PC = '0; id_target = '0;
    mm_b = 0; mm_b_taken = 0; flush = 0;
    resetn = 1'b1;
    #1 resetn = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst mispredict", mispredict, 1'b0);
    chk("rst redirect_pc", redirect_pc, 32'h0);
    chk("rst q_full", q_full, 1'b0);
    chk("rst q_empty", q_empty, 1'b1);
    chk("rst err_overflow", err_overflow, 1'b0);
    chk("rst err_underflow", err_underflow, 1'b0);
    chk("rst cnt_branch", cnt_branch, 0);
    chk("rst cnt_mispredict", cnt_mispredict, 0);
    resetn = 1'b1;

    tbl.push_back(v(1,1,'h100,'h200, 0,0,0, 0,0, 0,0, 0,0, 0,0));
    tbl.push_back(v(1,0,'h110,'h210, 0,0,0, 0,0, 0,0, 0,0, 0,0));
    tbl.push_back(v(1,1,'h120,'h220, 0,0,0, 0,0, 0,0, 0,0, 0,0));
    tbl.push_back(v(0,0,0,0,         1,1,0, 0,0, 0,0, 1,0, 0,0));
    tbl.push_back(v(0,0,0,0,         1,0,0, 0,0, 0,0, 2,0, 0,0));
    tbl.push_back(v(0,0,0,0,         1,1,0, 0,0, 0,1, 3,0, 0,0));
    tbl.push_back(v(1,1,'h100,'h200, 0,0,0, 0,0, 0,0, 3,0, 0,0));
    tbl.push_back(v(0,0,0,0,         1,0,0, 1,'h108, 0,1, 4,1, 0,0));
    tbl.push_back(v(0,0,0,0,         0,0,0, 0,0, 0,1, 4,1, 0,0));
    tbl.push_back(v(1,0,'h300,'h400, 0,0,0, 0,0, 0,0, 4,1, 0,0));
    tbl.push_back(v(0,0,0,0,         1,1,0, 1,'h400, 0,1, 5,2, 0,0));
    tbl.push_back(v(1,1,'h500,'h600, 0,0,0, 0,0, 0,0, 5,2, 0,0));
    tbl.push_back(v(1,0,'h510,'h610, 0,0,0, 0,0, 0,0, 5,2, 0,0));
    tbl.push_back(v(1,0,'h520,'h620, 1,0,0, 1,'h508, 0,1, 6,3, 0,0));
    tbl.push_back(v(0,0,0,0,         1,0,0, 0,0, 0,1, 6,3, 0,1));
    tbl.push_back(v(1,0,'h700,'h800, 0,0,0, 0,0, 0,0, 6,3, 0,1));
    tbl.push_back(v(1,0,'h710,'h810, 0,0,0, 0,0, 0,0, 6,3, 0,1));
    tbl.push_back(v(1,0,'h720,'h820, 0,0,0, 0,0, 0,0, 6,3, 0,1));
    tbl.push_back(v(1,0,'h730,'h830, 0,0,0, 0,0, 1,0, 6,3, 0,1));
    tbl.push_back(v(1,0,'h740,'h840, 0,0,0, 0,0, 1,0, 6,3, 1,1));
    tbl.push_back(v(1,1,'h750,'h850, 1,0,0, 0,0, 1,0, 7,3, 1,1));
    tbl.push_back(v(0,0,0,0,         1,0,0, 0,0, 0,0, 8,3, 1,1));
    tbl.push_back(v(0,0,0,0,         1,0,0, 0,0, 0,0, 9,3, 1,1));
    tbl.push_back(v(0,0,0,0,         1,0,0, 0,0, 0,0, 10,3, 1,1));
    tbl.push_back(v(0,0,0,0,         1,0,0, 1,'h758, 0,1, 11,4, 1,1));
    tbl.push_back(v(1,1,'h900,'hA00, 0,0,0, 0,0, 0,0, 11,4, 1,1));
    tbl.push_back(v(1,0,'h910,'hA10, 0,0,0, 0,0, 0,0, 11,4, 1,1));
    tbl.push_back(v(1,0,'h920,'hA20, 0,0,0, 0,0, 0,0, 11,4, 1,1));
    tbl.push_back(v(0,0,0,0,         1,0,1, 1,'h908, 0,1, 12,5, 1,1));
    tbl.push_back(v(0,0,0,0,         0,0,0, 0,0, 0,1, 12,5, 1,1));
    tbl.push_back(v(1,0,'hB00,'hB10, 0,0,0, 0,0, 0,0, 12,5, 1,1));
    tbl.push_back(v(1,0,'hB20,'hB30, 0,0,1, 0,0, 0,1, 12,5, 1,1));
    tbl.push_back(v(0,0,0,0,         1,0,0, 0,0, 0,1, 12,5, 1,1));

    @(negedge clk);
    foreach (tbl[i]) begin
      vec_t r;
      string tag;
      r = tbl[i];
      tag = $sformatf("vec%0d", i);
      step(r.b, r.p, r.pc, r.tgt, r.m, r.t, r.f, {tag, " model"});
      chk({tag, " mispredict"}, mispredict, r.x_mis);
      if (r.x_mis) chk({tag, " redirect_pc"}, redirect_pc, r.x_red);
      chk({tag, " q_full"}, q_full, r.x_full);
      chk({tag, " q_empty"}, q_empty, r.x_empty);
      chk({tag, " cnt_branch"}, cnt_branch, r.x_cb);
      chk({tag, " cnt_mispredict"}, cnt_mispredict, r.x_cm);
      chk({tag, " err_overflow"}, err_overflow, r.x_of);
      chk({tag, " err_underflow"}, err_underflow, r.x_uf);
    end

    // Async reset while a mispredict pulse is being shown.
    step(1, 1, 32'hC00, 32'hD00, 0, 0, 0, "ar push");
    step(0, 0, 32'h0, 32'h0, 1, 0, 0, "ar miss");
    chk("ar pulse before reset", mispredict, 1'b1);
    #2 resetn = 1'b0;
    #1;
    chk("ar mispredict", mispredict, 1'b0);
    chk("ar q_empty", q_empty, 1'b1);
    chk("ar q_full", q_full, 1'b0);
    chk("ar cnt_branch", cnt_branch, 0);
    chk("ar cnt_mispredict", cnt_mispredict, 0);
    chk("ar err_overflow", err_overflow, 1'b0);
    chk("ar err_underflow", err_underflow, 1'b0);
    model_reset();
    id_b = 0; mm_b = 0; flush = 0;
    @(negedge clk);
    resetn = 1'b1;
    step(0, 0, 32'h0, 32'h0, 0, 0, 0, "ar release");

    for (int n = 0; n < 3000; n++) begin
      bit b, p, m, t, f;
      logic [31:0] pc, tgt;
      b = ($urandom_range(0, 99) < 55);
      p = $urandom_range(0, 1) == 1;
      pc = $urandom & 32'hFFFF_FFFC;
      tgt = $urandom & 32'hFFFF_FFFC;
      m = ($urandom_range(0, 99) < 45);
      f = ($urandom_range(0, 99) < 3);
      if (mq.size() > 0 && $urandom_range(0, 99) < 85) t = mq[0].pred;
      else t = $urandom_range(0, 1) == 1;
      step(b, p, pc, tgt, m, t, f, $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
